piano_tone_decoder: RTL and testbench

- Receive-side counterpart of the piano tone generator: takes the single square-wave tone line and recovers which of the 8 keys is sounding.
- Measures the half-period of the incoming wave in clock cycles and matches it against the 8 note divider counts within a tolerance.
- Requires CONFIRM consecutive matching half-periods before reporting a key, and drops the key on mismatch or silence.
- Sits at the input of tone-loopback / auto-tuner logic on the same clock as the generator; handles single tones only (chords decode as no key).

---
 rtl/piano_pkg.sv | 9 +
 rtl/piano_period_meter.sv | 36 +++
 rtl/piano_tone_decoder.sv | 125 ++++++++++++
 tb/tb_piano_tone_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: shared key count, note divider table, decoder states and match helper
package piano_pkg;
  localparam int NUM_KEYS = 8;
  localparam int NOTE_CNT [0:NUM_KEYS-1] = '{3822, 3405, 3034, 2863, 2551, 2272, 2024, 1911};
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  function automatic logic note_near(input int a, input int b, input int tol);
    return ((a > b) ? a - b : b - a) <= tol;
  endfunction
endpackage

// File: rtl/piano_period_meter.sv
// piano_period_meter: synchronizes the tone line, flags either edge and measures half-periods
module piano_period_meter #(
  parameter int CNT_W   = 13,
  parameter int TIMEOUT = 5000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_tone,
  output logic             o_edge,
  output logic [CNT_W-1:0] o_meas,
  output logic             o_timeout
);
  localparam logic [CNT_W-1:0] L_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] L_TO1 = CNT_W'(TIMEOUT - 1);
  logic r_s1, r_s2, r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic w_edge;
  assign w_edge    = r_s2 ^ r_prev;
  assign o_edge    = w_edge;
  assign o_meas    = r_cnt;
  assign o_timeout = !w_edge && r_cnt == L_TO1;
  // sync chain, edge history and saturating half-period counter restarted at 1 on every edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_tone;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_cnt  <= w_edge ? CNT_W'(1) : (r_cnt != L_TO) ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule

// File: rtl/piano_tone_decoder.sv
// piano_tone_decoder: recovers the sounding key from a square-wave tone line; PIANO_DEC_PERIOD_OUT_EN adds the period port
module piano_tone_decoder
  import piano_pkg::*;
#(
  parameter int CNT_W   = 13,
  parameter int TOL     = 32,
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 5000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tone_in,
  output logic [NUM_KEYS-1:0] key,
  output logic [2:0]          note,
  output logic                locked,
  output logic                note_on
`ifdef PIANO_DEC_PERIOD_OUT_EN
  ,
  output logic [CNT_W-1:0]    period
`endif
);
  state_t r_state, w_state;
  logic [2:0] r_cand, w_cand, r_note, w_note, w_idx;
  logic [3:0] r_mcount, w_mcount;
  logic [NUM_KEYS-1:0] r_key;
  logic r_locked, w_locked, r_note_on, w_note_on;
  logic w_edge, w_timeout, w_hit;
  logic [CNT_W-1:0] w_meas;

  piano_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_meter (
    .clock     (clock),
    .reset     (reset),
    .i_tone    (tone_in),
    .o_edge    (w_edge),
    .o_meas    (w_meas),
    .o_timeout (w_timeout)
  );

  // nearest-note match; the tolerance keeps at most one index in range
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (note_near(int'(w_meas), NOTE_CNT[i], TOL)) begin
        w_hit = 1'b1;
        w_idx = 3'(i);
      end
  end

  // lock FSM: the first edge after silence only starts timing, later edges are classified
  always_comb begin
    w_state   = r_state;
    w_cand    = r_cand;
    w_mcount  = r_mcount;
    w_locked  = r_locked;
    w_note    = r_note;
    w_note_on = 1'b0;
    if (w_edge && r_state == IDLE) begin
      w_state  = ACQUIRE;
      w_mcount = '0;
    end else if (w_edge && !w_hit) begin
      w_state  = ACQUIRE;
      w_mcount = '0;
      w_locked = 1'b0;
      w_note   = '0;
    end else if (w_edge && r_state == LOCKED) begin
      if (w_idx != r_note) begin
        w_state  = ACQUIRE;
        w_cand   = w_idx;
        w_mcount = 4'd1;
        w_locked = 1'b0;
        w_note   = '0;
      end
    end else if (w_edge) begin
      w_cand   = w_idx;
      w_mcount = (w_idx == r_cand) ? r_mcount + 4'd1 : 4'd1;
      if (w_mcount >= 4'(CONFIRM)) begin
        w_state   = LOCKED;
        w_locked  = 1'b1;
        w_note    = w_idx;
        w_note_on = 1'b1;
      end
    end else if (w_timeout) begin
      w_state  = IDLE;
      w_locked = 1'b0;
      w_note   = '0;
    end
  end

  // state and registered outputs; timeout clears outputs as the counter saturates
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cand    <= '0;
      r_mcount  <= '0;
      r_locked  <= 1'b0;
      r_note    <= '0;
      r_key     <= '0;
      r_note_on <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cand    <= w_cand;
      r_mcount  <= w_mcount;
      r_locked  <= w_locked;
      r_note    <= w_note;
      r_key     <= w_locked ? NUM_KEYS'(1) << w_note : '0;
      r_note_on <= w_note_on;
    end
  end

`ifdef PIANO_DEC_PERIOD_OUT_EN
  logic [CNT_W-1:0] r_period;
  // last classified half-period, held between classifying edges
  always_ff @(posedge clock) begin
    if (reset) r_period <= '0;
    else if (w_edge && r_state != IDLE) r_period <= w_meas;
  end
  assign period = r_period;
`endif

  assign key     = r_key;
  assign note    = r_note;
  assign locked  = r_locked;
  assign note_on = r_note_on;
endmodule

// File: tb/tb_piano_tone_decoder.sv
// tb_piano_tone_decoder: directed tone sequences with hand-computed lock results
module tb_piano_tone_decoder;
  logic clk = 1'b0, reset = 1'b1, tone = 1'b0;
  logic [7:0] key;
  logic [2:0] note;
  logic locked, note_on;
`ifdef PIANO_DEC_PERIOD_OUT_EN
  logic [12:0] period;
`endif
  logic chord = 1'b0, wa = 1'b0, wb = 1'b0;
  int hp = 0, ne = 0, gcnt = 0, ga = 0, gb = 0;
  int on_cnt = 0, lock_cyc = 0, checks = 0, errors = 0;
  int on0, lk0;

  always #5 clk = ~clk;

  piano_tone_decoder dut (
    .clock   (clk),
    .reset   (reset),
    .tone_in (tone),
    .key     (key),
    .note    (note),
    .locked  (locked),
    .note_on (note_on)
`ifdef PIANO_DEC_PERIOD_OUT_EN
    , .period (period)
`endif
  );

  // pulse and lock-cycle tallies
  always @(posedge clk) begin
    on_cnt   <= on_cnt + int'(note_on);
    lock_cyc <= lock_cyc + int'(locked);
  end

  // tone source: toggles every hp clocks, or OR of two waves in chord mode
  initial forever begin
    @(posedge clk);
    #1;
    if (chord) begin
      ga++;
      gb++;
      gcnt = 0;
      if (ga == 3034) begin wa = ~wa; ga = 0; end
      if (gb == 2863) begin wb = ~wb; gb = 0; end
      tone = wa | wb;
    end else begin
      ga = 0;
      gb = 0;
      wa = 1'b0;
      wb = 1'b0;
      if (hp == 0) gcnt = 0;
      else begin
        gcnt++;
        if (gcnt >= hp) begin tone = ~tone; gcnt = 0; ne++; end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int k);
    int target;
    int n;
    target = ne + k;
    n = 0;
    while (ne < target && n < k * 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (ne >= target) else begin
      errors++;
      $error("FAIL edge_wait: observed %0d edges expected %0d", ne, target);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    hp = 5;
    repeat (20) @(negedge clk);
    chk("rst_key", key, 0);
    chk("rst_note", note, 0);
    chk("rst_locked", locked, 0);
    chk("rst_note_on", note_on, 0);
    hp = 0;
    reset = 1'b0;
    repeat (6000) @(negedge clk);
    chk("static_locked", locked, 0);
    chk("static_key", key, 0);

    hp = 3822;
    wait_edges(3);
    chk("c4_pre_locked", locked, 0);
    on0 = on_cnt;
    wait_edges(1);
    chk("c4_locked", locked, 1);
    chk("c4_key", key, 8'h01);
    chk("c4_note", note, 0);
    chk("c4_note_on", note_on, 1);
`ifdef PIANO_DEC_PERIOD_OUT_EN
    chk("c4_period", period, 3822);
`endif
    wait_edges(1);
    chk("c4_hold_locked", locked, 1);
    chk("c4_hold_key", key, 8'h01);
    chk("c4_hold_note_on", note_on, 0);
    chk("c4_pulses", on_cnt - on0, 1);

    hp = 3405;
    wait_edges(1);
    chk("d_drop_key", key, 0);
    chk("d_drop_locked", locked, 0);
    wait_edges(2);
    chk("d_locked", locked, 1);
    chk("d_key", key, 8'h02);
    chk("d_note", note, 1);
    hp = 0;
    repeat (4990) @(negedge clk);
    chk("sil_hold_locked", locked, 1);
    repeat (20) @(negedge clk);
    chk("sil_locked", locked, 0);
    chk("sil_key", key, 0);
    chk("sil_note", note, 0);

    hp = 2551;
    on0 = on_cnt;
    wait_edges(3);
    chk("g_pre_locked", locked, 0);
    wait_edges(1);
    chk("g_locked", locked, 1);
    chk("g_key", key, 8'h10);
    chk("g_note", note, 4);
    chk("g_note_on", note_on, 1);

    hp = 1911;
    wait_edges(1);
    chk("c5_drop_key", key, 0);
    chk("c5_drop_locked", locked, 0);
    wait_edges(1);
    chk("c5_pre_locked", locked, 0);
    wait_edges(1);
    chk("c5_key", key, 8'h80);
    chk("c5_note", note, 7);
    chk("c5_note_on", note_on, 1);
    chk("c5_pulses", on_cnt - on0, 1);

    hp = 2024 + 32;
    wait_edges(1);
    chk("tol_in_drop_key", key, 0);
    wait_edges(2);
    chk("tol_in_key", key, 8'h40);
    chk("tol_in_note", note, 6);
    hp = 2024 + 33;
    wait_edges(1);
    chk("tol_out_key", key, 0);
    chk("tol_out_locked", locked, 0);
    lk0 = lock_cyc;
    wait_edges(3);
    chk("tol_out_never", lock_cyc - lk0, 0);

    lk0 = lock_cyc;
    on0 = on_cnt;
    chord = 1'b1;
    repeat (9200) @(negedge clk);
    chk("chord_lock_cycles", lock_cyc - lk0, 0);
    chk("chord_pulses", on_cnt - on0, 0);
    hp = 2272;
    chord = 1'b0;

    on0 = on_cnt;
    wait_edges(5);
    chk("a_locked", locked, 1);
    chk("a_key", key, 8'h20);
    chk("a_note", note, 5);
    chk("a_pulses", on_cnt - on0, 1);
    on0 = on_cnt;
    hp = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_key", key, 0);
    chk("mid_rst_note", note, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_note_on", note_on, 0);
    repeat (5) @(negedge clk);
    chk("mid_rst_pulses", on_cnt - on0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
